// File: rtl/accel_drv.sv
// Valid/ready wrapper around the one-shot square + cube-root accelerator.
// Optional job counter port jobs_o is enabled by defining ACCEL_DRV_JOBCNT_EN.
module accel_drv #(
  parameter int unsigned WAIT_CYCLES = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  a_bi,
  input  logic [7:0]  b_bi,
  output logic        acc_rst_o,
  output logic [7:0]  acc_a_o,
  output logic [7:0]  acc_b_o,
  input  logic [15:0] acc_y_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] y_bo,
`ifdef ACCEL_DRV_JOBCNT_EN
  output logic [15:0] jobs_o,
`endif
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [7:0]         acc_a_r;
  logic [7:0]         acc_b_r;
  logic [15:0]        y_r;
  logic               out_valid_r;
`ifdef ACCEL_DRV_JOBCNT_EN
  logic [15:0]        jobs_r;
`endif

  // Job sequencing: load operands, run the fixed wait, capture and hold the result.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      acc_a_r     <= 8'd0;
      acc_b_r     <= 8'd0;
      y_r         <= 16'd0;
      out_valid_r <= 1'b0;
`ifdef ACCEL_DRV_JOBCNT_EN
      jobs_r      <= 16'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid_i) begin
            acc_a_r <= a_bi;
            acc_b_r <= b_bi;
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          cnt_r   <= CNT_W'(WAIT_CYCLES - 1);
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          // acc_y_i is only trusted on the final RUN cycle.
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            y_r         <= acc_y_i;
            out_valid_r <= 1'b1;
            state_r     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready_i) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
`ifdef ACCEL_DRV_JOBCNT_EN
            jobs_r      <= jobs_r + 16'd1;
`endif
          end else begin
            state_r <= ST_OUT;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_r == ST_IDLE);
  assign acc_rst_o   = (state_r != ST_RUN);
  assign busy_o      = (state_r != ST_IDLE);
  assign acc_a_o     = acc_a_r;
  assign acc_b_o     = acc_b_r;
  assign y_bo        = y_r;
  assign out_valid_o = out_valid_r;
`ifdef ACCEL_DRV_JOBCNT_EN
  assign jobs_o      = jobs_r;
`endif

endmodule
